muldiv_seq: RTL and testbench

Multi-cycle multiply/divide sequencer owning the MIPS HI/LO register pair. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage, runs a 32-iteration shift-add multiply or restoring divide, and holds `busy` so the pipeline stalls MFHI/MFLO and further mul/div issue until HI/LO are final. Sits beside the single-cycle ALU in EX; MFHI/MFLO read `hi`/`lo` directly.

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 35 +++
 rtl/muldiv_seq.sv | 150 +++++++++++++++
 tb/tb_muldiv_seq.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the HI/LO multiply/divide sequencer.
//   md_op_t    - execute-stage op encodings (6 and 7 are unused and ignored)
//   md_state_t - sequencer states
//   MD_ITER    - iteration count, equal to operand width
//   md_mag     - magnitude of a 32-bit operand, two's-complement only when signed
package muldiv_pkg;

  localparam int unsigned MD_ITER = 32;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FIX
  } md_state_t;

  function automatic logic [31:0] md_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the sequencer datapath.
//   is_div   in  1  : 1 = restoring-divide step, 0 = shift-add multiply step
//   acc      in  64 : mul {partial product, remaining multiplier}
//                     div {remainder, dividend/quotient}
//   opnd     in  32 : multiplicand (mul) or divisor (div) magnitude
//   acc_next out 64 : accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
(
  input  logic        is_div,
  input  logic [63:0] acc,
  input  logic [31:0] opnd,
  output logic [63:0] acc_next
);

  logic [32:0] sum;
  logic [32:0] rem_s;
  logic [31:0] diff;
  logic        ge;

  always_comb begin
    sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    rem_s = acc[63:31];
    ge    = rem_s >= {1'b0, opnd};
    // When the subtraction is kept the true difference is below the divisor,
    // so the low 32 bits carry the whole remainder.
    diff  = rem_s[31:0] - opnd;
    if (is_div) begin
      acc_next = ge ? {diff, acc[30:0], 1'b1} : {rem_s[31:0], acc[30:0], 1'b0};
    end else begin
      acc_next = {sum, acc[31:1]};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle MIPS multiply/divide sequencer owning HI/LO.
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   start     : issue strobe, sampled only while busy is low
//   op        : MD_MULT/MULTU/DIV/DIVU/MTHI/MTLO (6-7 ignored)
//   a, b      : rs / rt operands
//   busy      : operation in flight
//   done      : one-cycle pulse, HI/LO final this cycle
//   hi, lo    : architectural HI/LO
//   div_zero  : present only with MULDIV_DIVZERO_EN; pulses with done when a
//               divide by zero was short-circuited (HI/LO left unchanged)
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned ITER = MD_ITER
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
`ifdef MULDIV_DIVZERO_EN
  ,
  output logic        div_zero
`endif
);

  localparam int unsigned CW = $clog2(ITER);

  md_state_t     state, state_n;
  logic [CW-1:0] cnt;
  logic [63:0]   acc, acc_step;
  logic [31:0]   opnd;
  logic          is_div, neg_q, neg_r;
  logic          accept_md, sgn;
  logic [31:0]   res_hi, res_lo;
`ifdef MULDIV_DIVZERO_EN
  logic          dz;
`endif

  muldiv_step u_step (
    .is_div   (is_div),
    .acc      (acc),
    .opnd     (opnd),
    .acc_next (acc_step)
  );

  assign busy = (state != ST_IDLE);

  // RUN performs ITER-1 steps; the last step is taken in FIX together with
  // the sign fix-up, so HI/LO and done appear ITER+1 cycles after issue.
  always_comb begin
    state_n   = state;
    accept_md = 1'b0;
    sgn       = ~op[0];
    case (state)
      ST_IDLE: begin
        if (start && !op[2]) begin
          accept_md = 1'b1;
          state_n   = ST_RUN;
`ifdef MULDIV_DIVZERO_EN
          if (op[1] && b == '0) state_n = ST_FIX;
`endif
        end
      end
      ST_RUN:  if (cnt == CW'(ITER - 2)) state_n = ST_FIX;
      ST_FIX:  state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    res_hi = acc_step[63:32];
    res_lo = acc_step[31:0];
    if (is_div) begin
      if (neg_q) res_lo = -acc_step[31:0];
      if (neg_r) res_hi = -acc_step[63:32];
    end else if (neg_q) begin
      {res_hi, res_lo} = -acc_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      dz       <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      state <= state_n;
      done  <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
      div_zero <= 1'b0;
`endif
      if (state == ST_IDLE && start) begin
        if (op == MD_MTHI) hi <= a;
        if (op == MD_MTLO) lo <= a;
      end
      if (accept_md) begin
        is_div <= op[1];
        neg_q  <= sgn & (a[31] ^ b[31]);
        neg_r  <= sgn & a[31];
        cnt    <= '0;
        if (op[1]) begin
          acc  <= {32'd0, md_mag(a, sgn)};
          opnd <= md_mag(b, sgn);
        end else begin
          acc  <= {32'd0, md_mag(b, sgn)};
          opnd <= md_mag(a, sgn);
        end
`ifdef MULDIV_DIVZERO_EN
        dz <= op[1] && (b == '0);
`endif
      end
      if (state == ST_RUN) begin
        acc <= acc_step;
        cnt <= cnt + 1'b1;
      end
      if (state == ST_FIX) begin
        done <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
        if (dz) begin
          div_zero <= 1'b1;
        end else begin
          hi <= res_hi;
          lo <= res_lo;
        end
`else
        hi <= res_hi;
        lo <= res_lo;
`endif
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_EN
  logic        div_zero;
`endif

  muldiv_seq #(.ITER(MD_ITER)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
`ifdef MULDIV_DIVZERO_EN
    ,
    .div_zero (div_zero)
`endif
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nbad = 0;
  logic [31:0] hold_hi, hold_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Drive start for one edge; returns #1 after that edge (cycle 1).
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Steps cycle by cycle until done, bounded; checks busy and HI/LO hold on the way.
  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 60) begin
      if (cyc == 1)  chk("busy c1", 32'(busy), 32'd1);
      if (cyc == 10) begin
        chk("hold hi", hi, hold_hi);
        chk("hold lo", lo, hold_lo);
      end
      if (cyc == 32) chk("busy c32", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic watch_no_done(input string nm, input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen++;
    end
    chk(nm, 32'(seen), 32'd0);
  endtask

  initial begin
    int cyc;

    vecs[0] = '{MD_MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 33};
    vecs[1] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33};
    vecs[2] = '{MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33};
    vecs[3] = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
    vecs[4] = '{MD_MULT,  32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 33};
    vecs[5] = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       33};
    vecs[6] = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33};
    vecs[7] = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 33};
    vecs[8] = '{MD_DIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, 33};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    rst = 1'b0;

    // MTHI / MTLO visible in cycle 1 without busy or done
    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi hi", hi, 32'h1234);
    chk("mthi lo", lo, 32'd0);
    chk("mthi busy", 32'(busy), 32'd0);
    chk("mthi done", 32'(done), 32'd0);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo lo", lo, 32'h5678);
    chk("mtlo hi", hi, 32'h1234);

    // op 6 has no effect
    issue(3'd6, 32'hDEAD, 32'hBEEF);
    chk("op6 busy", 32'(busy), 32'd0);
    chk("op6 hi", hi, 32'h1234);
    chk("op6 lo", lo, 32'h5678);
    watch_no_done("op6 done", 3);

    // vectors issued back to back: each new start lands in the previous done cycle
    for (int i = 0; i < 9; i++) begin
      hold_hi = hi;
      hold_lo = lo;
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(1, cyc);
      chk($sformatf("v%0d cycle", i), 32'(cyc), 32'(vecs[i].cyc));
      chk($sformatf("v%0d hi", i), hi, vecs[i].hi);
      chk($sformatf("v%0d lo", i), lo, vecs[i].lo);
      chk($sformatf("v%0d busy@done", i), 32'(busy), 32'd0);
    end
    @(posedge clk);
    #1;
    chk("done pulse", 32'(done), 32'd0);

    // MULT issued during cycle 10 of a DIVU is dropped
    hold_hi = hi;
    hold_lo = lo;
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    start = 1'b1; op = MD_MULT; a = 32'd3; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(11, cyc);
    chk("ign cycle", 32'(cyc), 32'd33);
    chk("ign hi", hi, 32'd2);
    chk("ign lo", lo, 32'd14);
    watch_no_done("ign 2nd done", 40);

    // divide by zero
    hold_hi = hi;
    hold_lo = lo;
    issue(MD_DIVU, 32'd100, 32'd0);
    wait_done(1, cyc);
`ifdef MULDIV_DIVZERO_EN
    chk("dz cycle", 32'(cyc), 32'd2);
    chk("dz hi", hi, hold_hi);
    chk("dz lo", lo, hold_lo);
    chk("dz flag", 32'(div_zero), 32'd1);
    chk("dz busy", 32'(busy), 32'd0);
`else
    chk("dz cycle", 32'(cyc), 32'd33);
    chk("dz hi", hi, 32'd100);
    chk("dz lo", lo, 32'hFFFFFFFF);
`endif

    // reset in cycle 15 of a MULT discards it and clears HI/LO
    issue(MD_MTHI, 32'hAAAA5555, 32'd0);
    issue(MD_MULT, 32'h1111, 32'h2222);
    repeat (14) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst busy", 32'(busy), 32'd0);
    chk("mrst done", 32'(done), 32'd0);
    chk("mrst hi", hi, 32'd0);
    chk("mrst lo", lo, 32'd0);
    watch_no_done("mrst no done", 40);
    hold_hi = hi;
    hold_lo = lo;
    issue(MD_MULTU, 32'd3, 32'd5);
    wait_done(1, cyc);
    chk("post cycle", 32'(cyc), 32'd33);
    chk("post hi", hi, 32'd0);
    chk("post lo", lo, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
